// File: rtl/axi2ram.sv
// axi2ram: AXI4 slave that serves one burst at a time as single-beat RAM word commands
module axi2ram #(
  parameter int DATA_WD = 128,
  parameter int ADDR_WD = 32,
  parameter int ID_WD   = 4,
  parameter int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_WD-1:0]   awid,
  input  logic [ADDR_WD-1:0] awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [STRB_WD-1:0] wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [ID_WD-1:0]   bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  input  logic [ID_WD-1:0]   arid,
  input  logic [ADDR_WD-1:0] araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic               arvalid,
  output logic               arready,
  output logic [ID_WD-1:0]   rid,
  output logic [DATA_WD-1:0] rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic [ADDR_WD-1:0] ram_addr,
  output logic               ram_wr_en,
  output logic               ram_rd_en,
  output logic [DATA_WD-1:0] ram_w_data,
  output logic [STRB_WD-1:0] ram_strobe,
  input  logic [DATA_WD-1:0] ram_r_data
);
  localparam int SHIFT = $clog2(STRB_WD);
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;
  state_t state, state_nx;
  logic [ID_WD-1:0] id;
  logic [ADDR_WD-1:0] addr, addr_nx, inc, bound, mask;
  logic [7:0] len, cnt, icnt;
  logic [2:0] size;
  logic [1:0] burst;
  logic err, prio_w, idone, inflight, inflight_last;
  logic grant_w, grant_r, w_hs, issue, push, pop;
  logic [DATA_WD-1:0] fifo_data [2];
  logic [1:0] fifo_last;
  logic wp, rp;
  logic [1:0] occ;

  assign inc = ADDR_WD'(1) << size;
  assign bound = ADDR_WD'({1'b0, len} + 9'd1) << size;
  assign mask = bound - ADDR_WD'(1);
  assign addr_nx = burst == 2'b00 ? addr :
                   burst == 2'b10 ? (addr & ~mask) | ((addr + inc) & mask) : addr + inc;

  // grants are masked while reset is held so no handshake can be seen during reset
  always_comb begin
    state_nx = state;
    grant_w = 1'b0;
    grant_r = 1'b0;
    case (state)
      IDLE: begin
        grant_w = rst_n & awvalid & (prio_w | ~arvalid);
        grant_r = rst_n & arvalid & ~grant_w;
        state_nx = grant_w ? WRITE : grant_r ? READ : IDLE;
      end
      WRITE: state_nx = (wvalid && cnt == len) ? WRESP : WRITE;
      WRESP: state_nx = bready ? IDLE : WRESP;
      READ: state_nx = (pop && rlast) ? IDLE : READ;
      default: state_nx = IDLE;
    endcase
  end

  assign awready = grant_w;
  assign arready = grant_r;
  assign wready = state == WRITE;
  assign w_hs = wready & wvalid;
  assign bvalid = state == WRESP;
  assign bid = id;
  assign bresp = (bvalid && err) ? 2'b10 : 2'b00;
  assign rvalid = occ != 2'd0;
  assign pop = rvalid & rready;
  assign push = inflight;
  assign rid = id;
  assign rresp = 2'b00;
  assign rdata = fifo_data[rp];
  assign rlast = rvalid & fifo_last[rp];
  // a read may issue only if its beat is guaranteed a FIFO slot after this cycle's pop
  assign issue = state == READ && !idone &&
                 ({1'b0, occ} + {2'b0, inflight} + 3'd1) <= (3'd2 + {2'b0, pop});
  assign ram_rd_en = issue;
  assign ram_wr_en = w_hs;
  assign ram_addr = addr >> SHIFT;
  assign ram_w_data = wdata;
  assign ram_strobe = wstrb;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id <= '0;
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      cnt <= '0;
      icnt <= '0;
      err <= 1'b0;
      prio_w <= 1'b1;
      idone <= 1'b0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      fifo_last <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= '0;
    end else begin
      if (grant_w || grant_r) begin
        id <= grant_w ? awid : arid;
        addr <= grant_w ? awaddr : araddr;
        len <= grant_w ? awlen : arlen;
        size <= grant_w ? awsize : arsize;
        burst <= grant_w ? awburst : arburst;
        cnt <= '0;
        icnt <= '0;
        idone <= 1'b0;
        prio_w <= grant_r;
      end else if (w_hs || issue) begin
        addr <= addr_nx;
      end
      if (w_hs) begin
        cnt <= cnt + 8'd1;
        if (wlast != (cnt == len)) err <= 1'b1;
      end
      if (bvalid && bready) err <= 1'b0;
      if (issue) begin
        icnt <= icnt + 8'd1;
        idone <= icnt == len;
      end
      inflight <= issue;
      inflight_last <= issue && icnt == len;
      if (push) begin
        fifo_last[wp] <= inflight_last;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk)
    if (push) fifo_data[wp] <= ram_r_data;
endmodule

// File: tb/tb_axi2ram.sv
// tb_axi2ram: directed bench for axi2ram against a registered-read RAM model
module tb_axi2ram;
  logic clk = 0, rst_n = 0;
  logic [3:0] awid = 0, arid = 0, bid, rid;
  logic [31:0] awaddr = 0, araddr = 0, ram_addr;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rlast, rvalid, rready = 0, ram_wr_en, ram_rd_en;
  logic [127:0] wdata = 0, rdata, ram_w_data, ram_r_data;
  logic [15:0] wstrb = 0, ram_strobe;
  logic [127:0] mem [256];
  int n_cmp = 0, n_err = 0, cycn = 0, out_cnt = 0, max_out = 0;
  int first_rv, n_beats, ar_cyc, wb, rb;
  logic track = 0, dual = 0, r_done;
  logic [31:0] wr_q[$], rd_q[$];
  int wr_t[$], rd_t[$];
  logic [15:0] strb_q[$];
  logic [127:0] wd [8];
  logic [15:0] ws [8];
  logic [127:0] rcap [8];
  logic rlcap [8];
  logic [3:0] ridcap [8];

  axi2ram dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_w_data(ram_w_data), .ram_strobe(ram_strobe), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // RAM returns garbage whenever it was not read the previous cycle
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int i = 0; i < 16; i++)
        if (ram_strobe[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_w_data[8*i +: 8];
    ram_r_data <= ram_rd_en ? mem[ram_addr[7:0]] : {8{16'hBAD0}};
  end

  always begin
    @(negedge clk);
    #2;
    if (ram_wr_en) begin
      wr_q.push_back(ram_addr);
      wr_t.push_back(cycn);
      strb_q.push_back(ram_strobe);
    end
    if (ram_rd_en) begin
      rd_q.push_back(ram_addr);
      rd_t.push_back(cycn);
    end
    if (awready && arready) dual = 1;
    out_cnt = !rst_n ? 0 : out_cnt + int'(ram_rd_en) - int'(rvalid && rready);
    max_out = !track ? 0 : (out_cnt > max_out ? out_cnt : max_out);
    cycn++;
  end

  function automatic logic [127:0] dpat(input logic [31:0] base, input int b);
    return {4{base + 32'(b)}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_hs(input logic [3:0] i, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    awid = i; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1;
    #1;
    for (int k = 0; !awready && k < 20; k++) begin @(negedge clk); #1; end
    chk("aw_handshake", awready, 1);
    @(negedge clk);
    awvalid = 0;
  endtask

  task automatic ar_hs(input logic [3:0] i, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    arid = i; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1;
    #1;
    for (int k = 0; !arready && k < 20; k++) begin @(negedge clk); #1; end
    chk("ar_handshake", arready, 1);
    ar_cyc = cycn;
    @(negedge clk);
    arvalid = 0;
  endtask

  task automatic w_burst(input int n, input int lastb);
    for (int b = 0; b < n; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == lastb); wvalid = 1;
      #1;
      for (int k = 0; !wready && k < 20; k++) begin @(negedge clk); #1; end
      if (b == 0) chk("wready_first", wready, 1);
      @(negedge clk);
    end
    wvalid = 0;
    wlast = 0;
  endtask

  task automatic b_take(input logic [1:0] resp, input logic [3:0] i);
    #1;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, resp);
    chk("bid", bid, i);
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic r_drain(input bit slow);
    n_beats = 0; first_rv = -1; r_done = 0;
    for (int c = 1; c < 200 && !r_done; c++) begin
      rready = slow ? (c % 4 == 0) : 1'b1;
      #1;
      if (rvalid && first_rv < 0) first_rv = c;
      if (rvalid && rready && n_beats < 8) begin
        rcap[n_beats] = rdata; rlcap[n_beats] = rlast; ridcap[n_beats] = rid;
        n_beats++;
        r_done = rlast;
      end
      @(negedge clk);
    end
    rready = 0;
    chk("r_complete", r_done, 1);
  endtask

  initial begin
    awvalid = 1; arvalid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_ram_en", {ram_wr_en, ram_rd_en}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ids", {bid, rid, bresp, rresp}, 0);
    @(negedge clk);
    awvalid = 0; arvalid = 0; rst_n = 1;
    @(negedge clk);

    // INCR write then read of 0x100..0x13F
    for (int b = 0; b < 4; b++) begin wd[b] = dpat(32'hC0DE0000, b); ws[b] = 16'hFFFF; end
    wb = wr_q.size();
    aw_hs(1, 32'h100, 3, 4, 1);
    w_burst(4, 3);
    b_take(2'b00, 1);
    chk("incr_w_beats", wr_q.size() - wb, 4);
    for (int i = 0; i < 4; i++) chk("incr_w_addr", wr_q[wb+i], 32'h10 + i);
    chk("incr_w_back_to_back", wr_t[wb+3] - wr_t[wb], 3);
    rb = rd_q.size();
    ar_hs(5, 32'h100, 3, 4, 1);
    r_drain(0);
    chk("r_first_rvalid_lat", first_rv, 3);
    chk("r_first_rd_en_lat", rd_t[rb] - ar_cyc, 1);
    chk("incr_r_rid", ridcap[0], 5);
    for (int i = 0; i < 4; i++) begin
      chk("incr_r_addr", rd_q[rb+i], 32'h10 + i);
      chk("incr_r_data", rcap[i], dpat(32'hC0DE0000, i));
      chk("incr_r_rlast", rlcap[i], i == 3);
    end

    // WRAP read starting mid-window
    rb = rd_q.size();
    ar_hs(6, 32'h130, 3, 4, 2);
    r_drain(0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", rd_q[rb+i], 32'h10 + (i + 3) % 4);
      chk("wrap_data", rcap[i], dpat(32'hC0DE0000, (i + 3) % 4));
    end

    // narrow 32-bit INCR writes lane by lane
    wd[0] = {4{32'h11111111}}; ws[0] = 16'h00F0;
    wd[1] = {4{32'h22222222}}; ws[1] = 16'h0F00;
    wd[2] = {4{32'h33333333}}; ws[2] = 16'hF000;
    wd[3] = {4{32'h44444444}}; ws[3] = 16'h000F;
    wb = wr_q.size();
    aw_hs(7, 32'h204, 3, 2, 1);
    w_burst(4, 3);
    b_take(2'b00, 7);
    chk("narrow_addr0", wr_q[wb], 32'h20);
    chk("narrow_addr1", wr_q[wb+1], 32'h20);
    chk("narrow_addr2", wr_q[wb+2], 32'h20);
    chk("narrow_addr3", wr_q[wb+3], 32'h21);
    chk("narrow_last_strobe", strb_q[wb+3], 16'h000F);
    ar_hs(8, 32'h200, 1, 4, 1);
    r_drain(0);
    chk("narrow_word20", rcap[0] & {{96{1'b1}}, 32'h0}, {96'h33333333_22222222_11111111, 32'h0});
    chk("narrow_word21", rcap[1] & 128'hFFFFFFFF, 128'h44444444);

    // len=7 read under heavy R backpressure
    for (int b = 0; b < 8; b++) begin wd[b] = dpat(32'h5A5A0000, b); ws[b] = 16'hFFFF; end
    aw_hs(9, 32'h400, 7, 4, 1);
    w_burst(8, 7);
    b_take(2'b00, 9);
    track = 1;
    ar_hs(10, 32'h400, 7, 4, 1);
    r_drain(1);
    chk("bp_max_outstanding", max_out, 2);
    track = 0;
    chk("bp_beats", n_beats, 8);
    for (int i = 0; i < 8; i++) begin
      chk("bp_data", rcap[i], dpat(32'h5A5A0000, i));
      chk("bp_rlast", rlcap[i], i == 7);
    end

    // simultaneous AW/AR: write (read served last), then read, then write
    awid = 2; awaddr = 32'h500; awlen = 0; awsize = 4; awburst = 1; awvalid = 1;
    arid = 3; araddr = 32'h100; arlen = 0; arsize = 4; arburst = 1; arvalid = 1;
    #1;
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    @(negedge clk);
    awvalid = 0;
    wd[0] = dpat(32'h77770000, 0); ws[0] = 16'hFFFF;
    w_burst(1, 0);
    b_take(2'b00, 2);
    awid = 4; awaddr = 32'h600; awlen = 3; awvalid = 1;
    #1;
    chk("arb2_arready", arready, 1);
    chk("arb2_awready", awready, 0);
    @(negedge clk);
    arvalid = 0;
    r_drain(0);
    chk("arb2_rdata", rcap[0], dpat(32'hC0DE0000, 0));
    chk("arb2_rid", ridcap[0], 3);
    arvalid = 1;
    #1;
    chk("arb3_awready", awready, 1);
    chk("arb3_arready", arready, 0);
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    for (int b = 0; b < 4; b++) wd[b] = dpat(32'h66660000, b);
    wb = wr_q.size();
    w_burst(4, 1);
    b_take(2'b10, 4);
    chk("early_wlast_beats", wr_q.size() - wb, 4);

    // reset in the middle of a len=7 read
    ar_hs(11, 32'h400, 7, 4, 1);
    rready = 1;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_rdata", rdata, dpat(32'h5A5A0000, 2));
    rst_n = 0;
    #1;
    chk("rst_rvalid_drop", rvalid, 0);
    chk("rst_rd_en_drop", ram_rd_en, 0);
    @(negedge clk);
    #1;
    chk("rst_hold_rd_en", ram_rd_en, 0);
    @(negedge clk);
    rst_n = 1; rready = 0;
    @(negedge clk);
    ar_hs(12, 32'h400, 1, 4, 1);
    r_drain(0);
    chk("post_rst_beats", n_beats, 2);
    chk("post_rst_data0", rcap[0], dpat(32'h5A5A0000, 0));
    chk("post_rst_data1", rcap[1], dpat(32'h5A5A0000, 1));
    chk("post_rst_rid", ridcap[1], 12);

    chk("no_dual_grant", dual, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi2ram.md
# axi2ram

AXI4 slave front-end for the simulation memory model: accepts AXI4 read/write bursts from the DUT's memory port and converts them into single-beat word commands on the RAM port (addr/wr_en/rd_en/w_data/strobe/r_data, registered 1-cycle read). It serves one burst at a time, with round-robin arbitration between reads and writes, and buffers read data so R-channel backpressure never drops a beat.

## Interface
- DATA_WD, 128, data width of the AXI and RAM ports (bits)
- ADDR_WD, 32, AXI byte-address width; RAM word-address width
- ID_WD, 4, AXI ID width
- STRB_WD, DATA_WD/8, byte-strobe width

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- awid/awaddr/awlen/awsize/awburst  in  ID_WD/ADDR_WD/8/3/2  write address
- awvalid in 1, awready out 1  AW handshake
- wdata/wstrb/wlast  in  DATA_WD/STRB_WD/1  write data
- wvalid in 1, wready out 1  W handshake
- bid/bresp  out  ID_WD/2  write response
- bvalid out 1, bready in 1  B handshake
- arid/araddr/arlen/arsize/arburst  in  ID_WD/ADDR_WD/8/3/2  read address
- arvalid in 1, arready out 1  AR handshake
- rid/rdata/rresp/rlast  out  ID_WD/DATA_WD/2/1  read data
- rvalid out 1, rready in 1  R handshake
- ram_addr  out  ADDR_WD  RAM word address = byte addr >> log2(STRB_WD), zero-extended
- ram_wr_en/ram_rd_en  out  1  RAM write/read strobes
- ram_w_data/ram_strobe  out  DATA_WD/STRB_WD  write data and byte enables
- ram_r_data  in  DATA_WD  RAM read data, valid the cycle after ram_rd_en

## Operation
- FSM states: IDLE, WRITE, WRESP, READ.
- IDLE: awready = grant_w, arready = grant_r; exactly one is high when its valid is high. If both valids are high, the side not served last wins; after reset, write wins. Handshake latches id/addr/len/size/burst and sets beat counter = 0, then WRITE or READ.
- Address step: FIXED keeps addr. INCR adds 1<<size. WRAP: bound = (len+1)<<size; addr = (addr & ~(bound-1)) | ((addr + (1<<size)) & (bound-1)). Burst 2'b11 is treated as INCR. Any size up to log2(STRB_WD) is legal; narrow beats use the same RAM word, selected by strobes.
- WRITE: wready = 1. ram_wr_en = wvalid (combinational); ram_addr/ram_w_data/ram_strobe come from the current addr/wdata/wstrb. On each handshake, step addr and increment count. The beat counter is authoritative. If wlast != (count==len) on any beat, a sticky error is set. After beat len, go to WRESP.
- WRESP: bvalid = 1, bid = latched id, bresp = 2'b10 if error else 2'b00. On bready, clear error and go to IDLE.
- READ: the issue counter runs 0..len. Issue ram_rd_en with the current addr when occ - pop + inflight + 1 <= 2, where occ = 2-entry R FIFO count, pop = rvalid&rready, and inflight = registered copy of last cycle's ram_rd_en. When inflight = 1, ram_r_data is pushed into the FIFO. ram_r_data is ignored otherwise, because the RAM returns garbage when not read.
- FIFO head drives rdata and rvalid; rid = latched id; rresp = 2'b00; rlast is high on the FIFO entry tagged as beat len. When the rlast beat is accepted, go to IDLE.
- Outside WRITE, ram_wr_en = 0. Outside READ, ram_rd_en = 0.

## Timing
- Reset values: all ready/valid outputs 0, ram_wr_en = ram_rd_en = 0, bresp/rresp/bid/rid/rlast/ram_addr = 0, FIFO empty, inflight = 0, state IDLE, arbitration favours write.
- Reset asserted mid-burst abandons the burst immediately. Outputs go to reset values asynchronously, and no further RAM strobes are driven.
- AW handshake in cycle t gives first wready at t+1. One beat per cycle at full rate. The final W beat in cycle u gives bvalid at u+1.
- AR handshake in t gives ram_rd_en at t+1, FIFO push at end of t+2, and first rvalid at t+3. Sustained rate is 1 beat/cycle with rready high.
- rready held low: at most 2 reads are outstanding plus buffered, so no beat is lost. Issue resumes the cycle the FIFO is popped.
- The next AW/AR is accepted no earlier than the cycle after returning to IDLE. arready and awready are never high together.

## Test plan
- INCR write, awaddr=0x100, len=3, size=4, then INCR read of the same range -> ram_addr 0x10..0x13 on consecutive cycles, bresp=0, the 4 R beats return the written data, rlast on beat 3, first rvalid 3 cycles after AR handshake.
- WRAP read araddr=0x130, len=3, size=4 -> ram_addr sequence 0x13, 0x10, 0x11, 0x12.
- Narrow INCR write awaddr=0x204, size=2, len=3, wstrb=0x00F0/0x0F00/0xF000/0x000F -> ram_addr 0x20, 0x20, 0x20, 0x21; the final ram_strobe is 0x000F.
- Read len=7 with rready toggled 1 cycle high / 3 cycles low -> never more than 2 beats outstanding, all 8 beats arrive in order, rlast only on beat 7.
- awvalid and arvalid asserted together repeatedly -> grants alternate write, read, write. A write burst with wlast on beat 1 of len=3 completes 4 beats and returns bresp=2'b10.
- rst_n pulsed low during beat 2 of a len=7 read -> rvalid and ram_rd_en drop immediately. After release, a new AR is accepted from IDLE and returns correct data.
